// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
//
// Owns the PC and drives imem_addr straight from the PC register. The instruction that the
// combinational instruction memory returns for that address is registered into IF/ID along with
// its PC+4. Stalls from the hazard unit hold both the PC and IF/ID. A jump decoded in ID and a beq
// resolved in EX each redirect the PC. Both redirects squash IF/ID to a NOP (32'h0, valid low).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hazard unit: hold PC and IF/ID
//   j_inst         controller decode of id_inst is a jump
//   branch_taken   EX stage: beq taken this cycle
//   branch_target  EX stage: beq target address
//   imem_rdata     combinational instruction-memory read data for imem_addr
//   imem_addr      current PC
//   id_inst        IF/ID instruction
//   id_pc_plus4    IF/ID PC+4 of id_inst
//   id_valid       id_inst is a real, non-squashed instruction
//
// Optional build macro FETCH_PERF_EN adds two saturating 16-bit event counters:
//   perf_stall_cnt  edges on which a stall held the stage
//   perf_flush_cnt  edges on which IF/ID was squashed by a branch or jump

module fetch_stage #(
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0]  RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  j_inst,
    input  logic                  branch_taken,
    input  logic [INST_WIDTH-1:0] branch_target,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [INST_WIDTH-1:0] imem_addr,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [INST_WIDTH-1:0] id_pc_plus4,
    output logic                  id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           perf_stall_cnt,
    output logic [15:0]           perf_flush_cnt
`endif
);

    logic [INST_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [INST_WIDTH-1:0] pc4_q, pc4_d;
    logic                  valid_q, valid_d;

    logic [INST_WIDTH-1:0] pc_plus4;
    logic [INST_WIDTH-1:0] jump_target;
    logic                  take_stall;
    logic                  take_flush;

    // Wraps silently at the top of the address space.
    assign pc_plus4    = pc_q + INST_WIDTH'(4);
    assign jump_target = {pc4_q[31:28], inst_q[25:0], 2'b00};

    // The branch belongs to an older instruction than the jump in ID, so it outranks both the
    // stall and the jump. A jump is only honoured on a valid ID instruction.
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        take_stall = 1'b0;
        take_flush = 1'b0;
        if (branch_taken) begin
            pc_d       = branch_target;
            inst_d     = '0;
            pc4_d      = '0;
            valid_d    = 1'b0;
            take_flush = 1'b1;
        end else if (stall) begin
            take_stall = 1'b1;
        end else if (j_inst && valid_q) begin
            pc_d       = jump_target;
            inst_d     = '0;
            pc4_d      = '0;
            valid_d    = 1'b0;
            take_flush = 1'b1;
        end else begin
            pc_d    = pc_plus4;
            inst_d  = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_inst     = inst_q;
    assign id_pc_plus4 = pc4_q;
    assign id_valid    = valid_q;

`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (take_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (take_flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    // Event strobes only feed the optional counters.
    logic unused_events;
    assign unused_events = take_stall ^ take_flush;
`endif

endmodule
